// File: rtl/key192_exp_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : key192_exp_pkg                                               |
// | Description : Shared AES definitions: word type, key-expansion FSM state   |
// |               encoding, AES S-box table and round-constant table. Reused   |
// |               by the key-expansion and round blocks.                       |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package key192_exp_pkg;

   typedef logic [31:0] word_t;

   // Key-expansion controller states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } kx_state_t;

   // AES-192 produces words w0..w51; the last computed word index
   localparam logic [5:0] C_LAST_WORD = 6'd51;
   localparam int         C_NK        = 6;

   // Round constants Rcon(1)..Rcon(8), MSB byte only
   localparam logic [7:0] C_RCON [0:7] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
   };

   // FIPS-197 forward S-box
   localparam logic [7:0] C_SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
      return C_SBOX[b];
   endfunction

endpackage : key192_exp_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : aes_sbox                                                     |
// | Description : Purely combinational AES forward S-box, one byte.            |
// | Ports       : i_data [7:0]  input byte                                     |
// |               o_data [7:0]  substituted byte                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module aes_sbox
   import key192_exp_pkg::*;
(
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);

   always_comb begin
      o_data = sbox_lookup(i_data);
   end

endmodule : aes_sbox
`default_nettype wire

// File: rtl/key192_exp.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : key192_exp                                                   |
// | Description : AES-192 key expansion, one 32-bit word per clock. Emits the  |
// |               13 round keys rk0..rk12 as strobed 128-bit outputs.          |
// | Ports       : mclk          clock, rising edge                             |
// |               arst_n        asynchronous reset, active HIGH                |
// |               ck192_master  [0:191] cipher key (sampled on accepted start) |
// |               start         single-cycle expansion request                 |
// |               rk192         [0:127] current round key (registered)         |
// |               rk192_count   [3:0] round-key index 0..12 (registered)       |
// |               rk192_le      one-cycle strobe, rk192/rk192_count are new    |
// |               busy          expansion in progress                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module key192_exp
   import key192_exp_pkg::*;
(
   input  logic         mclk,
   input  logic         arst_n,
   input  logic [0:191] ck192_master,
   input  logic         start,
   output logic [0:127] rk192,
   output logic [3:0]   rk192_count,
   output logic         rk192_le,
   output logic         busy
);

   kx_state_t   r_state;
   kx_state_t   w_state_nxt;

   // Sliding window: r_win[0] = w(i-6) ... r_win[5] = w(i-1)
   word_t       r_win [0:5];
   logic [5:0]  r_i;      // index of the word computed on the next step
   logic [2:0]  r_ph;     // i mod 6, kept as a counter to avoid a divider
   logic [2:0]  r_rc;     // Rcon table index, i/6 - 1 when r_ph == 0

   logic [0:127] r_rk;
   logic [3:0]   r_cnt;
   logic         r_le;

   logic        w_accept;
   logic        w_step;
   logic        w_last;
   logic        w_emit;
   word_t       w_rot;
   word_t       w_sub;
   word_t       w_temp;
   word_t       w_new;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge mclk or posedge arst_n) begin
      if (arst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
         default:             w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_accept = (r_state == ST_IDLE) && start;
      w_step   = (r_state == ST_RUN);
      w_last   = w_step && (r_i == C_LAST_WORD);
   end

   assign busy = (r_state == ST_RUN);

   // ---------------------------------------------------------- datapath
   assign w_rot = {r_win[5][23:0], r_win[5][31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .i_data (w_rot[8*b +: 8]),
         .o_data (w_sub[8*b +: 8])
      );
   end

   always_comb begin
      if (r_ph == 3'd0) begin
         w_temp = w_sub ^ {C_RCON[r_rc], 24'h000000};
      end else begin
         w_temp = r_win[5];
      end
      w_new  = r_win[0] ^ w_temp;
      // A round key completes whenever the new word index is 3 mod 4
      w_emit = w_step && (r_i[1:0] == 2'b11);
   end

   always_ff @(posedge mclk or posedge arst_n) begin
      if (arst_n) begin
         for (int j = 0; j < C_NK; j++) begin
            r_win[j] <= '0;
         end
         r_i  <= '0;
         r_ph <= '0;
         r_rc <= '0;
      end else if (w_accept) begin
         for (int j = 0; j < C_NK; j++) begin
            r_win[j] <= ck192_master[32*j +: 32];
         end
         r_i  <= 6'd6;
         r_ph <= 3'd0;
         r_rc <= 3'd0;
      end else if (w_step) begin
         for (int j = 0; j < C_NK - 1; j++) begin
            r_win[j] <= r_win[j+1];
         end
         r_win[5] <= w_new;
         r_i      <= r_i + 6'd1;
         if (r_ph == 3'd5) begin
            r_ph <= 3'd0;
         end else begin
            r_ph <= r_ph + 3'd1;
         end
         if (r_ph == 3'd0) begin
            r_rc <= r_rc + 3'd1;
         end
      end
   end

   // ------------------------------------------------------------ outputs
   always_ff @(posedge mclk or posedge arst_n) begin
      if (arst_n) begin
         r_rk  <= '0;
         r_cnt <= '0;
         r_le  <= 1'b0;
      end else begin
         r_le <= 1'b0;
         if (w_accept) begin
            r_rk  <= ck192_master[0:127];
            r_cnt <= 4'd0;
            r_le  <= 1'b1;
         end else if (w_emit) begin
            // i = 4k+3, so k = i >> 2
            r_rk  <= {r_win[3], r_win[4], r_win[5], w_new};
            r_cnt <= r_i[5:2];
            r_le  <= 1'b1;
         end
      end
   end

   assign rk192       = r_rk;
   assign rk192_count = r_cnt;
   assign rk192_le    = r_le;

endmodule : key192_exp
`default_nettype wire

// File: tb/tb_key192_exp.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_key192_exp                                                |
// | Description : Directed self-checking bench for key192_exp using the        |
// |               FIPS-197 A.2 key and an all-zero key.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_key192_exp;

   logic         mclk;
   logic         arst_n;
   logic [0:191] ck192_master;
   logic         start;
   logic [0:127] rk192;
   logic [3:0]   rk192_count;
   logic         rk192_le;
   logic         busy;

   int n_vec;
   int n_err;

   localparam logic [191:0] C_KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [191:0] C_KEY_B  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] C_A2_RK0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
   localparam logic [127:0] C_A2_RK1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
   localparam logic [127:0] C_A2_RK2  = 128'hec12068e6c827f6b0e7a95b95c56fec2;
   localparam logic [127:0] C_A2_RK12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] C_Z_RK1   = 128'h00000000000000006263636362636363;
   localparam logic [127:0] C_Z_RK2   = 128'h62636363626363636263636362636363;

   key192_exp u_dut (
      .mclk         (mclk),
      .arst_n       (arst_n),
      .ck192_master (ck192_master),
      .start        (start),
      .rk192        (rk192),
      .rk192_count  (rk192_count),
      .rk192_le     (rk192_le),
      .busy         (busy)
   );

   initial begin
      mclk = 1'b0;
      forever #5 mclk = ~mclk;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Starts an expansion at the next rising edge (T) and follows it to T+46.
   // Called at a falling edge. With poke=1 a second start with another key is
   // applied so that it is sampled at T+10.
   task automatic do_expand(input logic [191:0] key, input logic poke,
                            input logic [127:0] e0, input logic [127:0] e1,
                            input logic [127:0] e2, input logic [127:0] e12,
                            input logic chk12);
      logic [127:0] got [0:12];
      int           n_pulse;
      logic         exp_le;
      int           exp_cnt;
      n_pulse      = 0;
      for (int j = 0; j < 13; j++) got[j] = '0;
      ck192_master = key;
      start        = 1'b1;
      @(posedge mclk);                 // edge T
      for (int k = 0; k <= 46; k++) begin
         @(negedge mclk);              // samples state after edge T+k
         start        = 1'b0;
         ck192_master = ~key;          // must be ignored outside the accept edge
         exp_le  = (k == 0) || (k >= 2 && ((k + 2) % 4) == 0);
         exp_cnt = (k == 0) ? 0 : (k + 2) / 4;
         check("le", {127'd0, rk192_le}, {127'd0, exp_le});
         check("busy", {127'd0, busy}, {127'd0, (k <= 45)});
         if (rk192_le) begin
            if (n_pulse < 13) got[n_pulse] = rk192;
            n_pulse++;
         end
         if (exp_le) check("cnt", {124'd0, rk192_count}, exp_cnt[127:0]);
         if (poke && k == 9) begin
            start        = 1'b1;
            ck192_master = C_KEY_B;
         end
      end
      check("npulse", n_pulse[127:0], 128'd13);
      check("rk0", got[0], e0);
      check("rk1", got[1], e1);
      check("rk2", got[2], e2);
      if (chk12) check("rk12", got[12], e12);
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      start        = 1'b0;
      ck192_master = '0;
      arst_n       = 1'b1;

      // Reset: outputs forced to zero while asserted
      #10;
      check("rst_rk", rk192, 128'd0);
      check("rst_cnt", {124'd0, rk192_count}, 128'd0);
      check("rst_le", {127'd0, rk192_le}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      arst_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge mclk);
         check("idle_le", {127'd0, rk192_le}, 128'd0);
         check("idle_busy", {127'd0, busy}, 128'd0);
      end

      // FIPS-197 A.2 expansion with timing checks
      do_expand(C_KEY_A2, 1'b0, C_A2_RK0, C_A2_RK1, C_A2_RK2, C_A2_RK12, 1'b1);
      // Back-to-back: accepted at T+47 with an all-zero key
      do_expand(192'd0, 1'b0, 128'd0, C_Z_RK1, C_Z_RK2, 128'd0, 1'b0);

      // Reset abort at T+20
      ck192_master = C_KEY_A2;
      start        = 1'b1;
      @(posedge mclk);
      #1 start = 1'b0;
      repeat (20) @(posedge mclk);
      #1;
      check("abort_busy_pre", {127'd0, busy}, 128'd1);
      #1 arst_n = 1'b1;
      #1;
      check("abort_rk", rk192, 128'd0);
      check("abort_cnt", {124'd0, rk192_count}, 128'd0);
      check("abort_le", {127'd0, rk192_le}, 128'd0);
      check("abort_busy", {127'd0, busy}, 128'd0);
      @(negedge mclk);
      arst_n = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge mclk);
         check("post_le", {127'd0, rk192_le}, 128'd0);
         check("post_busy", {127'd0, busy}, 128'd0);
      end
      do_expand(C_KEY_A2, 1'b0, C_A2_RK0, C_A2_RK1, C_A2_RK2, C_A2_RK12, 1'b1);

      // Start while busy is ignored
      @(negedge mclk);
      do_expand(C_KEY_A2, 1'b1, C_A2_RK0, C_A2_RK1, C_A2_RK2, C_A2_RK12, 1'b1);

      // Outputs hold after completion
      repeat (3) @(negedge mclk);
      check("hold_rk", rk192, C_A2_RK12);
      check("hold_cnt", {124'd0, rk192_count}, 128'd12);
      check("hold_le", {127'd0, rk192_le}, 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_key192_exp
`default_nettype wire
